cv32e40p_tmr_fault_manager: RTL and testbench

CV32E40P_TMR_FAULT_MANAGER -- requirements
Module: cv32e40p_tmr_fault_manager

---
 rtl/cv32e40p_tmr_fault_manager.sv | 175 +++++++++++++++++
 tb/tb_cv32e40p_tmr_fault_manager.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: counts per-replica outvotes, sequences resyncs, degrades and flags fatal errors.
// Optional correction-cycle statistics counter enabled by defining CV32E40P_TMR_FM_STATS_EN.
module cv32e40p_tmr_fault_manager #(
    parameter int unsigned N_IN       = 1,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ERR_THRESH = 16,
    parameter int unsigned MAX_RESYNC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vote_valid_i,
    input  logic [N_IN-1:0]       err_corrected_i,
    input  logic [N_IN-1:0]       err_detected_i,
    input  logic [N_IN-1:0][2:0]  faulty_rep_i,
    output logic                  resync_req_o,
    output logic [2:0]            resync_rep_o,
    input  logic                  resync_ack_i,
    output logic [2:0]            rep_disable_o,
    output logic                  fatal_o,
    output logic [1:0]            state_o
`ifdef CV32E40P_TMR_FM_STATS_EN
    ,
    output logic [31:0]           stat_corr_cnt_o
`endif
);

    localparam int unsigned RC_W = (MAX_RESYNC < 1) ? 1 : $clog2(MAX_RESYNC + 1);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(ERR_THRESH);
    localparam logic [RC_W-1:0]  MAX_RC = RC_W'(MAX_RESYNC);

    typedef enum logic [1:0] {
        MONITOR  = 2'b00,
        RESYNC   = 2'b01,
        DEGRADED = 2'b10,
        FATAL    = 2'b11
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0][CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [2:0][RC_W-1:0]   rc_q, rc_d;
    logic                   req_q, req_d;
    logic [2:0]             rep_q, rep_d;
    logic [2:0]             dis_q, dis_d;
    logic                   fatal_q, fatal_d;
    logic [2:0]             hit;
    logic                   fatal_cond;
    logic                   any_det;
    logic                   found;

    always_comb begin
        hit = '0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            for (int unsigned r = 0; r < 3; r++) begin
                if (err_corrected_i[k] && faulty_rep_i[k][r]) hit[r] = 1'b1;
            end
        end
        hit        = hit & {3{vote_valid_i}};
        fatal_cond = vote_valid_i && |(err_detected_i & ~err_corrected_i);
        any_det    = vote_valid_i && |err_detected_i;
        for (int unsigned r = 0; r < 3; r++) begin
            cnt_inc[r] = (hit[r] && cnt_q[r] != '1) ? cnt_q[r] + 1'b1 : cnt_q[r];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rc_d    = rc_q;
        req_d   = req_q;
        rep_d   = rep_q;
        dis_d   = dis_q;
        fatal_d = fatal_q;
        found   = 1'b0;
        unique case (state_q)
            MONITOR: begin
                if (fatal_cond) begin
                    state_d = FATAL;
                    fatal_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    // Lowest-index replica wins when several cross the threshold together.
                    for (int unsigned r = 0; r < 3; r++) begin
                        if (!found && cnt_inc[r] >= THRESH) begin
                            found    = 1'b1;
                            rep_d    = '0;
                            rep_d[r] = 1'b1;
                        end
                    end
                    if (found) begin
                        state_d = RESYNC;
                        req_d   = 1'b1;
                    end
                end
            end
            RESYNC: begin
                if (fatal_cond) begin
                    state_d = FATAL;
                    fatal_d = 1'b1;
                    req_d   = 1'b0;
                end else begin
                    for (int unsigned r = 0; r < 3; r++) begin
                        if (!rep_q[r]) cnt_d[r] = cnt_inc[r];
                    end
                    if (resync_ack_i) begin
                        for (int unsigned r = 0; r < 3; r++) begin
                            if (rep_q[r]) begin
                                cnt_d[r] = '0;
                                rc_d[r]  = rc_q[r] + 1'b1;
                                if (rc_d[r] >= MAX_RC) dis_d[r] = 1'b1;
                            end
                        end
                        req_d   = 1'b0;
                        rep_d   = '0;
                        state_d = (|(dis_d & rep_q)) ? DEGRADED : MONITOR;
                    end
                end
            end
            DEGRADED: begin
                if (any_det) begin
                    state_d = FATAL;
                    fatal_d = 1'b1;
                end
            end
            FATAL: begin
                req_d   = 1'b0;
                fatal_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MONITOR;
            cnt_q   <= '0;
            rc_q    <= '0;
            req_q   <= 1'b0;
            rep_q   <= '0;
            dis_q   <= '0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            req_q   <= req_d;
            rep_q   <= rep_d;
            dis_q   <= dis_d;
            fatal_q <= fatal_d;
        end
    end

    assign resync_req_o  = req_q;
    assign resync_rep_o  = rep_q;
    assign rep_disable_o = dis_q;
    assign fatal_o       = fatal_q;
    assign state_o       = state_q;

`ifdef CV32E40P_TMR_FM_STATS_EN
    logic [31:0] stat_q, stat_d;

    always_comb begin
        stat_d = stat_q;
        if (state_q != FATAL && vote_valid_i && |err_corrected_i && stat_q != '1) begin
            stat_d = stat_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stat_q <= '0;
        else     stat_q <= stat_d;
    end

    assign stat_corr_cnt_o = stat_q;
`endif

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Directed self-checking bench for cv32e40p_tmr_fault_manager (ERR_THRESH=4, MAX_RESYNC=2, N_IN=2).
module tb_cv32e40p_tmr_fault_manager;

    localparam int unsigned N_IN = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 vote_valid_i;
    logic [N_IN-1:0]      err_corrected_i;
    logic [N_IN-1:0]      err_detected_i;
    logic [N_IN-1:0][2:0] faulty_rep_i;
    logic                 resync_req_o;
    logic [2:0]           resync_rep_o;
    logic                 resync_ack_i;
    logic [2:0]           rep_disable_o;
    logic                 fatal_o;
    logic [1:0]           state_o;
`ifdef CV32E40P_TMR_FM_STATS_EN
    logic [31:0]          stat_corr_cnt_o;
`endif

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    cv32e40p_tmr_fault_manager #(
        .N_IN       (N_IN),
        .CNT_W      (8),
        .ERR_THRESH (4),
        .MAX_RESYNC (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .vote_valid_i    (vote_valid_i),
        .err_corrected_i (err_corrected_i),
        .err_detected_i  (err_detected_i),
        .faulty_rep_i    (faulty_rep_i),
        .resync_req_o    (resync_req_o),
        .resync_rep_o    (resync_rep_o),
        .resync_ack_i    (resync_ack_i),
        .rep_disable_o   (rep_disable_o),
        .fatal_o         (fatal_o),
        .state_o         (state_o)
`ifdef CV32E40P_TMR_FM_STATS_EN
        ,
        .stat_corr_cnt_o (stat_corr_cnt_o)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] st, input logic req,
                            input logic [2:0] rep, input logic [2:0] dis, input logic fat);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".req"}, 32'(resync_req_o), 32'(req));
        chk({tag, ".rep"}, 32'(resync_rep_o), 32'(rep));
        chk({tag, ".dis"}, 32'(rep_disable_o), 32'(dis));
        chk({tag, ".fatal"}, 32'(fatal_o), 32'(fat));
    endtask

    task automatic idle();
        vote_valid_i    = 1'b0;
        err_corrected_i = '0;
        err_detected_i  = '0;
        faulty_rep_i    = '0;
    endtask

    task automatic drive(input logic [1:0] c, input logic [1:0] d,
                         input logic [2:0] f0, input logic [2:0] f1);
        vote_valid_i    = 1'b1;
        err_corrected_i = c;
        err_detected_i  = d;
        faulty_rep_i[0] = f0;
        faulty_rep_i[1] = f1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        resync_ack_i = 1'b0;
        idle();
        step();
        step();
        rst = 1'b0;
        chk_outs("reset", 2'b00, 1'b0, 3'b000, 3'b000, 1'b0);

        // Five correction cycles spread over replicas so no counter reaches 4.
        drive(2'b01, 2'b01, 3'b001, 3'b000); step();
        drive(2'b01, 2'b01, 3'b010, 3'b000); step();
        drive(2'b10, 2'b10, 3'b000, 3'b100); step();
        drive(2'b01, 2'b01, 3'b001, 3'b000); step();
        drive(2'b01, 2'b01, 3'b010, 3'b000); step();
        chk("spread.state", 32'(state_o), 32'd0);
        idle(); step();
`ifdef CV32E40P_TMR_FM_STATS_EN
        chk("stat5", stat_corr_cnt_o, 32'd5);
`endif
        do_reset();

        // Replica 2 outvoted four times; stray ack in MONITOR must be ignored.
        resync_ack_i = 1'b1;
        drive(2'b01, 2'b01, 3'b010, 3'b000);
        step(); step(); step();
        chk_outs("hit3", 2'b00, 1'b0, 3'b000, 3'b000, 1'b0);
        resync_ack_i = 1'b0;
        step();
        chk_outs("resync1", 2'b01, 1'b1, 3'b010, 3'b000, 1'b0);
        step(); step();
        chk_outs("resync1.hold", 2'b01, 1'b1, 3'b010, 3'b000, 1'b0);
        idle();
        resync_ack_i = 1'b1;
        step();
        resync_ack_i = 1'b0;
        chk_outs("ack1", 2'b00, 1'b0, 3'b000, 3'b000, 1'b0);
        drive(2'b01, 2'b01, 3'b010, 3'b000);
        step(); step(); step();
        chk("cleared.state", 32'(state_o), 32'd0);
        step();
        chk_outs("resync2", 2'b01, 1'b1, 3'b010, 3'b000, 1'b0);
        idle();
        resync_ack_i = 1'b1;
        step();
        resync_ack_i = 1'b0;
        chk_outs("degraded", 2'b10, 1'b0, 3'b000, 3'b010, 1'b0);
        drive(2'b01, 2'b00, 3'b001, 3'b000);
        step(); step(); step(); step(); step();
        chk_outs("degraded.hold", 2'b10, 1'b0, 3'b000, 3'b010, 1'b0);
        drive(2'b10, 2'b10, 3'b000, 3'b001);
        step();
        chk_outs("degraded.fatal", 2'b11, 1'b0, 3'b000, 3'b010, 1'b1);
        idle();
        resync_ack_i = 1'b1;
        step(); step();
        resync_ack_i = 1'b0;
        chk_outs("fatal.hold", 2'b11, 1'b0, 3'b000, 3'b010, 1'b1);
        do_reset();
        chk_outs("reset2", 2'b00, 1'b0, 3'b000, 3'b000, 1'b0);

        // Uncorrectable mismatch in MONITOR.
        drive(2'b00, 2'b01, 3'b000, 3'b000);
        step();
        chk_outs("fatal", 2'b11, 1'b0, 3'b000, 3'b000, 1'b1);
        idle();
        step(); step(); step();
        chk_outs("fatal.sticky", 2'b11, 1'b0, 3'b000, 3'b000, 1'b1);
        do_reset();

        // Replicas 1 and 3 hit the threshold together.
        drive(2'b11, 2'b11, 3'b001, 3'b100);
        step(); step(); step(); step();
        chk_outs("tie", 2'b01, 1'b1, 3'b001, 3'b000, 1'b0);
        idle();
        resync_ack_i = 1'b1;
        step();
        resync_ack_i = 1'b0;
        chk_outs("tie.ack", 2'b00, 1'b0, 3'b000, 3'b000, 1'b0);
        step();
        chk_outs("tie.second", 2'b01, 1'b1, 3'b100, 3'b000, 1'b0);

        // Reset mid-handshake with fatal stimulus present must win.
        rst = 1'b1;
        drive(2'b00, 2'b01, 3'b000, 3'b000);
        resync_ack_i = 1'b1;
        step();
        chk_outs("rst.midhs", 2'b00, 1'b0, 3'b000, 3'b000, 1'b0);
        rst = 1'b0;
        resync_ack_i = 1'b0;
        idle();
        step();
        chk("rst.after", 32'(state_o), 32'd0);

        // Status inputs without vote_valid_i must be ignored.
        drive(2'b01, 2'b11, 3'b010, 3'b000);
        vote_valid_i = 1'b0;
        step(); step(); step(); step(); step();
        chk_outs("novalid", 2'b00, 1'b0, 3'b000, 3'b000, 1'b0);

        // Fatal during RESYNC drops the request.
        drive(2'b01, 2'b01, 3'b010, 3'b000);
        step(); step(); step(); step();
        chk("resync3.req", 32'(resync_req_o), 32'd1);
        drive(2'b00, 2'b01, 3'b000, 3'b000);
        step();
        chk("rsfatal.state", 32'(state_o), 32'd3);
        chk("rsfatal.req", 32'(resync_req_o), 32'd0);
        chk("rsfatal.fatal", 32'(fatal_o), 32'd1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
